uart_frame_decoder: RTL

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

---
 rtl/uart_frame_pkg.sv | 17 +
 rtl/uart_frame_timeout.sv | 28 ++
 rtl/uart_frame_decoder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared frame constants and decoder state encoding for the UART control-frame decoder.
package uart_frame_pkg;

    localparam logic [7:0] HDR0_BYTE = 8'hAA;
    localparam logic [7:0] HDR1_BYTE = 8'hA5;
    localparam logic [7:0] TAIL_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR1  = 3'd1,
        ADDR  = 3'd2,
        DATA  = 3'd3,
        CKSUM = 3'd4,
        TAIL  = 3'd5
    } state_t;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte silence counter: expire pulses after TIMEOUT_CYC enabled cycles without a clear.
module uart_frame_timeout #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic n_reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] cnt;

    // clear wins over expiry so a byte landing on the last cycle is never lost
    assign expire = enable && !clear && (cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            cnt <= '0;
        else if (clear || expire || !enable)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_frame_decoder.sv
// Decodes AA A5 ADDR DATA [CKSUM] FF frames into per-channel control words.
// Define UART_FRAME_CKSUM_EN to require a (ADDR+DATA) mod 256 checksum byte before TAIL.
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CTRL_W      = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_done,
    output logic [NUM_CH*CTRL_W-1:0] ctrl,
    output logic                     ctrl_valid,
    output logic [NUM_CH-1:0]        ch_upd,
    output logic                     frame_err
);

`ifdef UART_FRAME_CKSUM_EN
    localparam int DW = 8;
`else
    localparam int DW = CTRL_W;
`endif

    state_t state, state_nxt;
    logic   rx_done_q;
    logic   accept;
    logic   expire;
    logic   wr, err;
    logic [7:0]    addr_q, addr_nxt;
    logic [DW-1:0] data_q, data_nxt;
    logic [NUM_CH-1:0]             upd_nxt;
    logic [NUM_CH-1:0][CTRL_W-1:0] ctrl_q;

    // a held strobe counts once: only the low-to-high transition accepts a byte
    assign accept = rx_done && !rx_done_q;
    assign ctrl   = ctrl_q;

    uart_frame_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .n_reset (n_reset),
        .clear   (accept || (state == IDLE)),
        .enable  (state != IDLE),
        .expire  (expire)
    );

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        wr        = 1'b0;
        err       = 1'b0;
        if (expire) begin
            err       = 1'b1;
            state_nxt = IDLE;
        end else if (accept) begin
            case (state)
                IDLE: if (rx_data == HDR0_BYTE) state_nxt = HDR1;
                HDR1: begin
                    if (rx_data == HDR1_BYTE)      state_nxt = ADDR;
                    else if (rx_data != HDR0_BYTE) state_nxt = IDLE;
                end
                ADDR: begin
                    addr_nxt = rx_data;
                    if (rx_data >= 8'(NUM_CH)) begin
                        err       = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    data_nxt = rx_data[DW-1:0];
`ifdef UART_FRAME_CKSUM_EN
                    state_nxt = CKSUM;
`else
                    state_nxt = TAIL;
`endif
                end
`ifdef UART_FRAME_CKSUM_EN
                CKSUM: begin
                    if (rx_data == 8'(addr_q + 8'(data_q))) begin
                        state_nxt = TAIL;
                    end else begin
                        err       = 1'b1;
                        state_nxt = IDLE;
                    end
                end
`endif
                TAIL: begin
                    if (rx_data == TAIL_BYTE) wr  = 1'b1;
                    else                      err = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        upd_nxt = '0;
        for (int k = 0; k < NUM_CH; k++)
            upd_nxt[k] = wr && (addr_q == 8'(k));
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            rx_done_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            ctrl_q     <= '0;
            ctrl_valid <= 1'b0;
            ch_upd     <= '0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            rx_done_q  <= rx_done;
            addr_q     <= addr_nxt;
            data_q     <= data_nxt;
            ctrl_valid <= wr;
            ch_upd     <= upd_nxt;
            frame_err  <= err;
            for (int k = 0; k < NUM_CH; k++)
                if (upd_nxt[k]) ctrl_q[k] <= data_q[CTRL_W-1:0];
        end
    end

endmodule
